if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline CPU: owns the PC, drives the instruction-memory word address and registers each fetched word with its PC+4 into the IF/ID pipeline register. It is the supplier of the `opcode`/`func` fields that the main control decoder consumes. It also applies stalls from the hazard unit and redirects from branch/jump resolution, and halts fetch on the STOP opcode (6'h3F).

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/if_id_reg.sv | 58 +++++
 rtl/if_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the five-stage pipeline CPU.
//
// Contents:
//   - opcode constants used by the fetch stage and the main control decoder
//   - the canonical NOP encoding used to fill pipeline bubbles
//   - instruction field slice positions and small helpers to extract them
//   - the fetch-stage run/halt state encoding
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Primary opcodes.
   // OP_RTYPE selects the func field.
   // OP_STOP stops instruction fetch.
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_STOP  = 6'd63;

   // All-zero word.
   // It decodes as RTYPE/SLL $0,$0,0, which has no architectural effect.
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   // Instruction field positions
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNC_MSB   = 5;
   localparam int FUNC_LSB   = 0;

   // The PC is always word aligned, so the low two bits are masked off.
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   // Fetch stage run state.
   // HALT is entered by capturing a STOP word.
   // HALT is left only by a redirect or a reset.
   typedef enum logic {
      FETCH_RUN  = 1'b0,
      FETCH_HALT = 1'b1
   } fetch_state_t;

   // Extract the primary opcode from an instruction word
   function automatic logic [5:0] get_opcode(input logic [31:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   // Extract the R-type function code from an instruction word
   function automatic logic [5:0] get_func(input logic [31:0] instr);
      return instr[FUNC_MSB:FUNC_LSB];
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Pipeline register holding one instruction slot.
// The register is written as a generic stage register so that it can be
// reused between later stages.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; the slot becomes a bubble
//   hold       in   keep the current contents
//   flush      in   replace the contents with a bubble (NOP, pc4=0, invalid)
//   load       in   capture next_instr/next_pc4 as a valid instruction
//   next_instr in   instruction word to capture
//   next_pc4   in   PC+4 belonging to next_instr
//   instr      out  registered instruction word
//   pc4        out  registered PC+4
//   valid      out  slot holds a real instruction
//
// Control priority is: rst, then flush, then hold, then load.
// If none of these controls is asserted, the register keeps its contents.
// ---------------------------------------------------------------------------
module if_id_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] next_instr,
   input  logic [31:0] next_pc4,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   // Slot update.
   // Flush beats hold, so that a redirect during a stall still kills the
   // wrong-path instruction.
   // A bubble always carries pc4=0 so that it is distinguishable from a
   // real instruction in waveforms.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         instr <= INSTR_NOP;
         pc4   <= 32'h0000_0000;
         valid <= 1'b0;
      end else if (hold) begin
         instr <= instr;
         pc4   <= pc4;
         valid <= valid;
      end else if (load) begin
         instr <= next_instr;
         pc4   <= next_pc4;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the five-stage pipeline CPU.
// The stage owns the PC and addresses the instruction memory.
// Each fetched word is registered, together with its PC+4, into the IF/ID
// register.
// The stage also applies hazard stalls and branch/jump redirects.
// Fetch halts when a STOP word is captured.
//
// Parameters:
//   RESET_PC         PC value loaded on reset
//   IMEM_AW          instruction-memory word-address width
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   imem_addr        out  word address, pc[IMEM_AW+1:2], driven from the
//                         PC register only
//   imem_rdata       in   instruction word at imem_addr; same-cycle read
//   stall            in   freeze the PC, IF/ID and the fetch counter
//   redirect         in   load the PC from redirect_target and flush IF/ID
//   redirect_target  in   new PC; the low two bits are ignored
//   if_id_instr      out  registered instruction (NOP when bubble)
//   if_id_pc4        out  registered PC+4 of if_id_instr
//   if_id_valid      out  IF/ID holds a real instruction
//   opcode           out  if_id_instr[31:26]
//   func             out  if_id_instr[5:0]
//   halted           out  fetch stopped by STOP
//   fetch_cnt        out  count of valid instructions captured into IF/ID
// ---------------------------------------------------------------------------
module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 8
)
(
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_target,
   output logic [31:0]        if_id_instr,
   output logic [31:0]        if_id_pc4,
   output logic               if_id_valid,
   output logic [5:0]         opcode,
   output logic [5:0]         func,
   output logic               halted,
   output logic [31:0]        fetch_cnt
);

   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  pc_plus4;
   logic [31:0]  cnt_next;
   fetch_state_t state;
   fetch_state_t state_next;
   logic         reg_hold;
   logic         reg_flush;
   logic         reg_load;

   // The memory address is a pure slice of the PC register.
   // Neither stall nor redirect can reach it combinationally.
   // Truncating the slice provides the wrap modulo 2^IMEM_AW.
   assign imem_addr = pc[IMEM_AW+1:2];

   // 32-bit add, so PC+4 wraps naturally from 0xFFFF_FFFC to 0
   assign pc_plus4 = pc + 32'd4;

   assign halted = (state == FETCH_HALT);

   // The decoder fields are plain slices of the IF/ID register.
   // A bubble therefore decodes as RTYPE/SLL with zero operands.
   assign opcode = get_opcode(if_id_instr);
   assign func   = get_func(if_id_instr);

   // State register for the PC, the fetch counter and the run/halt state.
   // Reset is synchronous and wins over every other control.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         fetch_cnt <= 32'h0000_0000;
         state     <= FETCH_RUN;
      end else begin
         pc        <= pc_next;
         fetch_cnt <= cnt_next;
         state     <= state_next;
      end
   end

   // Priority of the fetch controls is redirect, then halted, then stall,
   // then normal fetch.
   // Redirect overrides both the halt and the stall, so that a STOP word
   // fetched on a wrong path can be recovered from.
   // A captured STOP word is counted as a real fetch, but the PC stays on
   // it; the following cycles then only insert bubbles.
   always_comb begin
      pc_next    = pc;
      cnt_next   = fetch_cnt;
      state_next = state;
      reg_hold   = 1'b0;
      reg_flush  = 1'b0;
      reg_load   = 1'b0;

      if (redirect) begin
         pc_next    = redirect_target & PC_ALIGN_MASK;
         reg_flush  = 1'b1;
         state_next = FETCH_RUN;
      end else if (state == FETCH_HALT) begin
         reg_flush = 1'b1;
      end else if (stall) begin
         reg_hold = 1'b1;
      end else begin
         reg_load = 1'b1;
         cnt_next = fetch_cnt + 32'd1;
         if (get_opcode(imem_rdata) == OP_STOP) begin
            state_next = FETCH_HALT;
         end else begin
            pc_next = pc_plus4;
         end
      end
   end

   // IF/ID pipeline register
   if_id_reg u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .hold       (reg_hold),
      .flush      (reg_flush),
      .load       (reg_load),
      .next_instr (imem_rdata),
      .next_pc4   (pc_plus4),
      .instr      (if_id_instr),
      .pc4        (if_id_pc4),
      .valid      (if_id_valid)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage.
// A small instruction ROM feeds the stage.
// Every expected value below is worked out by hand from the program layout.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;
   import cpu_pkg::*;

   localparam int IMEM_AW = 8;

   // Instruction words used in the program
   localparam logic [31:0] W_ADD  = 32'h0022_1820;
   localparam logic [31:0] W_SUB  = 32'h0022_1822;
   localparam logic [31:0] W_OR   = 32'h0022_1825;
   localparam logic [31:0] W_AND  = 32'h0022_1824;
   localparam logic [31:0] W_STOP = 32'hFC00_0000;
   localparam logic [31:0] W_A20  = 32'h00A6_2020;
   localparam logic [31:0] W_A40  = 32'h012A_4022;
   localparam logic [31:0] W_AFC  = 32'h016C_5825;

   logic               clk = 1'b0;
   logic               rst;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               stall;
   logic               redirect;
   logic [31:0]        redirect_target;
   logic [31:0]        if_id_instr;
   logic [31:0]        if_id_pc4;
   logic               if_id_valid;
   logic [5:0]         opcode;
   logic [5:0]         func;
   logic               halted;
   logic [31:0]        fetch_cnt;

   logic [31:0] imem [256];

   int numChecks = 0;
   int numPassed = 0;

   always #5 clk = ~clk;

   // Combinational-read instruction memory
   assign imem_rdata = imem[imem_addr];

   if_fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .IMEM_AW  (IMEM_AW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_id_instr     (if_id_instr),
      .if_id_pc4       (if_id_pc4),
      .if_id_valid     (if_id_valid),
      .opcode          (opcode),
      .func            (func),
      .halted          (halted),
      .fetch_cnt       (fetch_cnt)
   );

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed === expected) begin
         numPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Check the full visible state of the stage
   task automatic checkState(input string tag, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [31:0] pc4,
                             input logic valid, input logic hlt,
                             input logic [31:0] cnt);
      checkOutput({tag, ".addr"},   32'(imem_addr),   addr);
      checkOutput({tag, ".instr"},  if_id_instr,      instr);
      checkOutput({tag, ".pc4"},    if_id_pc4,        pc4);
      checkOutput({tag, ".valid"},  32'(if_id_valid), 32'(valid));
      checkOutput({tag, ".halted"}, 32'(halted),      32'(hlt));
      checkOutput({tag, ".cnt"},    fetch_cnt,        cnt);
   endtask

   // Drive one cycle of inputs, then let a rising edge pass.
   // Sampling happens 1 time unit after the edge.
   task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                input logic [31:0] tgt);
      rst             = r;
      stall           = s;
      redirect        = rd;
      redirect_target = tgt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0000;
      imem[0]   = W_ADD;
      imem[1]   = W_SUB;
      imem[2]   = W_OR;
      imem[3]   = W_AND;
      imem[4]   = W_STOP;
      imem[8]   = W_A20;
      imem[16]  = W_A40;
      imem[255] = W_AFC;

      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkState("reset", 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

      // Sequential fetch from address 0
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("f0", 32'd1, W_ADD, 32'd4, 1'b1, 1'b0, 32'd1);
      checkOutput("f0.opcode", 32'(opcode), 32'(OP_RTYPE));
      checkOutput("f0.func", 32'(func), 32'h20);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("f1", 32'd2, W_SUB, 32'd8, 1'b1, 1'b0, 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("f2", 32'd3, W_OR, 32'd12, 1'b1, 1'b0, 32'd3);

      // Stall for 3 cycles with the word from 0x8 in IF/ID
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         checkState($sformatf("stall%0d", k), 32'd3, W_OR, 32'd12, 1'b1, 1'b0, 32'd3);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("resume", 32'd4, W_AND, 32'd16, 1'b1, 1'b0, 32'd4);

      // STOP at 0x10: it is captured, then halted is raised and bubbles follow
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("stop", 32'd4, W_STOP, 32'h14, 1'b1, 1'b1, 32'd5);
      checkOutput("stop.opcode", 32'(opcode), 32'(OP_STOP));
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("halt0", 32'd4, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkState("halt1", 32'd4, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5);

      // Redirect while halted, to 0x20
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0020);
      checkState("rdh", 32'd8, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("rdh.cap", 32'd9, W_A20, 32'h24, 1'b1, 1'b0, 32'd6);

      // Redirect to 0x43 together with stall: the PC becomes 0x40
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0043);
      checkState("rds", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("rds.cap", 32'h11, W_A40, 32'h44, 1'b1, 1'b0, 32'd7);
      checkOutput("rds.func", 32'(func), 32'h22);

      // The PC wraps from 0xFFFF_FFFC to 0
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checkState("wrap.rd", 32'hFF, 32'h0, 32'h0, 1'b0, 1'b0, 32'd7);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("wrap.cap", 32'd0, W_AFC, 32'h0, 1'b1, 1'b0, 32'd8);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("wrap.next", 32'd1, W_ADD, 32'd4, 1'b1, 1'b0, 32'd9);

      // Reset during a stall wins
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkState("rst.stall", 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("rst.after", 32'd1, W_ADD, 32'd4, 1'b1, 1'b0, 32'd1);

      // Reset during a halt wins: go to STOP first
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState("stop2", 32'd4, W_STOP, 32'h14, 1'b1, 1'b1, 32'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkState("rst.halt", 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

      $display("[TB] %0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
